cv32e40x_aes_mask_rng: RTL and testbench

//  Producer of masking randomness for the protected AES functional unit (DOM S-box datapath).

---
 rtl/cv32e40x_aes_rng_pkg.sv | 15 +
 rtl/cv32e40x_aes_rng_fifo.sv | 34 +++
 rtl/cv32e40x_aes_mask_rng.sv | 75 +++++++
 tb/tb_cv32e40x_aes_mask_rng.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cv32e40x_aes_rng_pkg.sv
// cv32e40x_aes_rng_pkg: shared widths, LFSR taps, 44-step LFSR function and FSM states for the AES mask RNG
package cv32e40x_aes_rng_pkg;
  localparam int unsigned LFSR_W = 64;
  localparam int unsigned RNG_WORD_W = 44;
  localparam int unsigned SHARE_W = 8;
  localparam int unsigned RAND_W = 36;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  typedef enum logic [1:0] {UNSEEDED, WARMUP, RUN} rng_state_e;
  function automatic logic [LFSR_W-1:0] lfsr_step44(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < RNG_WORD_W; i++) r = {r[LFSR_W-2:0], ^(r & LFSR_TAPS)};
    return r;
  endfunction
endpackage

// File: rtl/cv32e40x_aes_rng_fifo.sv
// cv32e40x_aes_rng_fifo: sync FIFO with flush, wrap-around pointers and zero output while empty
module cv32e40x_aes_rng_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W = 44
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  assign empty_o = wptr_q == rptr_q;
  assign full_o = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/cv32e40x_aes_mask_rng.sv
// cv32e40x_aes_mask_rng: LFSR-based masking randomness source with warm-up, FIFO buffering and reseed request
module cv32e40x_aes_mask_rng
  import cv32e40x_aes_rng_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned RESEED_INTERVAL = 4096
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  seed_valid_i,
  input  logic [LFSR_W-1:0]     seed_i,
  input  logic                  rng_ready_i,
  output logic                  rng_valid_o,
  output logic [SHARE_W-1:0]    shareB_o,
  output logic [RAND_W-1:0]     randombits_o,
  output logic                  seeded_o,
  output logic                  reseed_req_o
);
  localparam int unsigned WCW = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned PCW = $clog2(RESEED_INTERVAL + 1);
  rng_state_e state_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [WCW-1:0] warm_q;
  logic [PCW-1:0] pop_cnt_q;
  logic seeded_q, reseed_q, full, empty, pop, push, step;
  logic [RNG_WORD_W-1:0] head;
  assign lfsr_d = lfsr_step44(lfsr_q);
  assign rng_valid_o = !empty;
  assign pop = !empty && rng_ready_i;
  assign push = !seed_valid_i && state_q == RUN && (!full || pop);
  assign step = state_q == WARMUP || push;
  assign shareB_o = head[RNG_WORD_W-1:RAND_W];
  assign randombits_o = head[RAND_W-1:0];
  assign seeded_o = seeded_q;
  assign reseed_req_o = reseed_q;
  cv32e40x_aes_rng_fifo #(.DEPTH(FIFO_DEPTH), .W(RNG_WORD_W)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (seed_valid_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (lfsr_d[RNG_WORD_W-1:0]),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= UNSEEDED;
      lfsr_q <= LFSR_W'(1);
      warm_q <= '0;
      pop_cnt_q <= '0;
      seeded_q <= 1'b0;
      reseed_q <= 1'b0;
    end else if (seed_valid_i) begin
      state_q <= WARMUP;
      lfsr_q <= (seed_i == '0) ? LFSR_W'(1) : seed_i;
      warm_q <= '0;
      pop_cnt_q <= '0;
      seeded_q <= 1'b1;
      reseed_q <= 1'b0;
    end else begin
      if (step) lfsr_q <= lfsr_d;
      if (state_q == WARMUP) begin
        warm_q <= warm_q + 1'b1;
        if (warm_q == WCW'(WARMUP_CYCLES - 1)) state_q <= RUN;
      end
      if (pop && pop_cnt_q != PCW'(RESEED_INTERVAL)) begin
        pop_cnt_q <= pop_cnt_q + 1'b1;
        if (pop_cnt_q == PCW'(RESEED_INTERVAL - 1)) reseed_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cv32e40x_aes_mask_rng.sv
// tb_cv32e40x_aes_mask_rng: randomized and directed checks of the mask RNG against a word-stream model
module tb_cv32e40x_aes_mask_rng;
  import cv32e40x_aes_rng_pkg::*;
  localparam int DEPTH = 2;
  localparam int WARM = 16;
  localparam int RI = 8;
  logic clk = 1'b0;
  logic reset_n, seed_valid, rdy;
  logic [63:0] seed;
  logic rng_valid;
  logic [7:0] share_b;
  logic [35:0] rbits;
  logic seeded, reseed_req;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  bit m_seeded = 0, m_req = 0;
  int m_since = 0, m_pops = 0;
  logic [63:0] m_gen = 64'h1;
  logic [43:0] q[$];
  always #5 clk = ~clk;
  cv32e40x_aes_mask_rng #(.FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARM), .RESEED_INTERVAL(RI)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .seed_valid_i (seed_valid),
    .seed_i       (seed),
    .rng_ready_i  (rdy),
    .rng_valid_o  (rng_valid),
    .shareB_o     (share_b),
    .randombits_o (rbits),
    .seeded_o     (seeded),
    .reseed_req_o (reseed_req)
  );
  function automatic logic [63:0] ref_step(input logic [63:0] s);
    logic fb;
    for (int i = 0; i < 44; i++) begin
      fb = s[63] ^ s[62] ^ s[60] ^ s[59];
      s = {s[62:0], fb};
    end
    return s;
  endfunction
  function automatic logic [43:0] nth_word(input logic [63:0] sd, input int k);
    logic [63:0] s;
    s = (sd == 64'h0) ? 64'h1 : sd;
    for (int i = 0; i < WARM + 1 + k; i++) s = ref_step(s);
    return s[43:0];
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    bit pop, push;
    pop = q.size() > 0 && rdy;
    @(posedge clk);
    if (!reset_n) begin
      m_seeded = 0; m_gen = 64'h1; q.delete(); m_pops = 0; m_req = 0;
    end else if (seed_valid) begin
      m_seeded = 1; m_since = 0; m_gen = (seed == 64'h0) ? 64'h1 : seed; q.delete(); m_pops = 0; m_req = 0;
    end else if (m_seeded) begin
      m_since++;
      push = m_since > WARM && (q.size() < DEPTH || pop);
      if (m_since <= WARM || push) m_gen = ref_step(m_gen);
      if (pop) begin
        void'(q.pop_front());
        if (m_pops < RI) m_pops++;
      end
      if (push) q.push_back(m_gen[43:0]);
      m_req = m_pops == RI;
    end
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(rng_valid), 64'(q.size() > 0));
      check("head", {20'h0, share_b, rbits}, {20'h0, (q.size() > 0) ? q[0] : 44'h0});
      check("seeded", 64'(seeded), 64'(m_seeded));
      check("reseed_req", 64'(reseed_req), 64'(m_req));
    end
  end
  initial begin
    int lat, zeros;
    logic [63:0] r, s6;
    logic [43:0] hold;
    reset_n = 0; seed_valid = 0; seed = 64'h0; rdy = 0;
    check("pin_step_1", ref_step(64'h1), 64'h0000_1000_0000_0000);
    check("pin_step_msb", ref_step(64'h8000_0000_0000_0000), 64'h0000_0800_0000_0000);
    for (int i = 0; i < 8; i++) begin
      r = {$urandom, $urandom};
      check("pkg_step", lfsr_step44(r), ref_step(r));
    end
    @(negedge clk);
    tick();
    chk_en = 1;
    reset_n = 1;
    rdy = 1;
    repeat (100) tick();
    check("t1_valid", 64'(rng_valid), 0);
    check("t1_seeded", 64'(seeded), 0);
    check("t1_head", {20'h0, share_b, rbits}, 0);
    seed = 64'h0123456789ABCDEF; seed_valid = 1;
    tick();
    seed_valid = 0;
    lat = 0;
    while (!rng_valid && lat < 40) begin
      tick();
      lat++;
    end
    check("t2_latency", 64'(lat), 17);
    check("t2_seeded", 64'(seeded), 1);
    for (int k = 0; k < 5; k++) begin
      check("t2_word", {20'h0, share_b, rbits}, {20'h0, nth_word(64'h0123456789ABCDEF, k)});
      tick();
    end
    seed = 64'h0; seed_valid = 1;
    tick();
    seed_valid = 0;
    repeat (17) tick();
    for (int k = 0; k < 20; k++) begin
      check("t3_zero_seed", {20'h0, share_b, rbits}, {20'h0, nth_word(64'h1, k)});
      tick();
    end
    zeros = 0;
    repeat (10000) begin
      if (rng_valid && {share_b, rbits} == 44'h0) zeros++;
      tick();
    end
    check("t3_nonzero", 64'(zeros), 0);
    rdy = 0;
    repeat (3) tick();
    check("t4_full_valid", 64'(rng_valid), 1);
    hold = q[0];
    repeat (50) begin
      tick();
      check("t4_stable", {20'h0, share_b, rbits}, {20'h0, hold});
    end
    rdy = 1;
    repeat (10) tick();
    seed = {$urandom, $urandom}; seed_valid = 1;
    tick();
    seed_valid = 0;
    repeat (24) tick();
    check("t5_req_pre", 64'(reseed_req), 0);
    tick();
    check("t5_req", 64'(reseed_req), 1);
    repeat (5) tick();
    check("t5_flow", 64'(rng_valid), 1);
    check("t5_req_hold", 64'(reseed_req), 1);
    seed = {$urandom, $urandom}; seed_valid = 1;
    tick();
    seed_valid = 0;
    check("t5_req_clr", 64'(reseed_req), 0);
    check("t5_flush", 64'(rng_valid), 0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t5_gap", 64'(rng_valid), 0);
    end
    tick();
    check("t5_resume", 64'(rng_valid), 1);
    repeat (3) tick();
    s6 = {$urandom, $urandom};
    seed = s6; seed_valid = 1; rdy = 1;
    tick();
    seed_valid = 0;
    repeat (17) tick();
    check("t6_post", {20'h0, share_b, rbits}, {20'h0, nth_word(s6, 0)});
    repeat (4) tick();
    reset_n = 0;
    tick();
    reset_n = 1;
    check("t6_rst_seeded", 64'(seeded), 0);
    check("t6_rst_valid", 64'(rng_valid), 0);
    repeat (3000) begin
      rdy = $urandom_range(0, 3) != 0;
      seed_valid = $urandom_range(0, 149) == 0;
      seed = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
      reset_n = $urandom_range(0, 599) != 0;
      tick();
    end
    reset_n = 1; seed_valid = 0;
    tick();
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
